// File: rtl/uart_filt_pkg.sv
// Shared types and constants for the UART <-> filter stream controller.
package uart_filt_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    RECV  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3
  } state_e;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_filter_ctrl_byte_shifter.sv
// NBYTES x 8 register with parallel load, indexed byte write and indexed byte read.
module byte_shifter
  import uart_filt_pkg::*;
#(
  parameter  int NBYTES = 2,
  localparam int W      = NBYTES * BYTE_W,
  localparam int IW     = idx_w(NBYTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [W-1:0]      load_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [BYTE_W-1:0] wr_byte,
  input  logic [IW-1:0]     rd_idx,
  output logic [BYTE_W-1:0] rd_byte,
  output logic [W-1:0]      q
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wr_idx == IW'(i)) data_d[i*BYTE_W +: BYTE_W] = wr_byte;
      end
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (rd_idx == IW'(i)) rd_byte = data_q[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/uart_filter_ctrl.sv
// Streams little-endian multi-byte samples RX FIFO -> filter -> TX FIFO with channel tagging.
// Optional FILT_BYPASS_EN adds a `bypass` input that routes samples straight to TX.
module uart_filter_ctrl
  import uart_filt_pkg::*;
#(
  parameter  int SAMPLE_BYTES = 2,
  parameter  int NUM_CH       = 2,
  localparam int SAMPLE_W     = 8 * SAMPLE_BYTES,
  localparam int CH_W         = idx_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_empty,
  input  logic [7:0]          r_data,
  output logic                rd_uart,
  input  logic                tx_full,
  output logic [7:0]          w_data,
  output logic                wr_uart,
  output logic [SAMPLE_W-1:0] filt_in,
  output logic [CH_W-1:0]     filt_ch,
  output logic                filt_start,
  input  logic                filt_done,
  input  logic [SAMPLE_W-1:0] filt_out,
`ifdef FILT_BYPASS_EN
  input  logic                bypass,
`endif
  output logic [2:0]          state,
  output logic                busy
);

  localparam int BI_W = idx_w(SAMPLE_BYTES);

  state_e            state_q, state_d;
  logic [BI_W-1:0]   bi_q, bi_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              byp;
  logic              last_byte;
  logic              rd, wr, start, asm_wr, res_load;
  logic [7:0]        asm_rd_byte, res_rd_byte;
  logic [SAMPLE_W-1:0] unused_res_q;

`ifdef FILT_BYPASS_EN
  logic byp_q, byp_d;
  assign byp = byp_q;
`else
  assign byp = 1'b0;
`endif

  assign last_byte = (bi_q == BI_W'(SAMPLE_BYTES - 1));

  always_comb begin
    state_d  = state_q;
    bi_d     = bi_q;
    ch_d     = ch_q;
    rd       = 1'b0;
    wr       = 1'b0;
    start    = 1'b0;
    asm_wr   = 1'b0;
    res_load = 1'b0;
`ifdef FILT_BYPASS_EN
    byp_d    = byp_q;
`endif
    case (state_q)
      RECV: begin
        if (!rx_empty) begin
          rd     = 1'b1;
          asm_wr = 1'b1;
          if (last_byte) begin
            bi_d    = '0;
            state_d = START;
`ifdef FILT_BYPASS_EN
            byp_d = bypass;
            if (bypass) state_d = SEND;
`endif
          end else begin
            bi_d = bi_q + 1'b1;
          end
        end
      end
      START: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (filt_done) begin
          res_load = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr = 1'b1;
          if (last_byte) begin
            bi_d    = '0;
            state_d = RECV;
            ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          end else begin
            bi_d = bi_q + 1'b1;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RECV;
      bi_q    <= '0;
      ch_q    <= '0;
`ifdef FILT_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      ch_q    <= ch_d;
`ifdef FILT_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  byte_shifter #(.NBYTES(SAMPLE_BYTES)) u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (1'b0),
    .load_data ('0),
    .wr_en     (asm_wr),
    .wr_idx    (bi_q),
    .wr_byte   (r_data),
    .rd_idx    (bi_q),
    .rd_byte   (asm_rd_byte),
    .q         (filt_in)
  );

  byte_shifter #(.NBYTES(SAMPLE_BYTES)) u_res (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (res_load),
    .load_data (filt_out),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_byte   ('0),
    .rd_idx    (bi_q),
    .rd_byte   (res_rd_byte),
    .q         (unused_res_q)
  );

  // Bypassed samples are sent from the assembly register, which stays intact
  // until the next RX pop; this gives the N+1 first push without a copy cycle.
  assign w_data     = byp ? asm_rd_byte : res_rd_byte;
  assign rd_uart    = rd & reset_n;
  assign wr_uart    = wr;
  assign filt_start = start;
  assign filt_ch    = ch_q;
  assign state      = state_q;
  assign busy       = !((state_q == RECV) && (bi_q == '0));

endmodule

// File: tb/tb_uart_filter_ctrl.sv
// Directed bench for uart_filter_ctrl: default 2-byte/2-channel instance plus a 1-byte/1-channel instance.
module tb_uart_filter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic reset_n;
  logic rx_hold, tx_full, extra_done;
  logic [7:0] rx_buf [0:31];
  int   rx_wr = 0;
  int   rx_rd = 0;

  logic        rx_empty, rd_uart, wr_uart, filt_start, filt_done, busy;
  logic [7:0]  r_data, w_data;
  logic [15:0] filt_in, filt_out;
  logic [0:0]  filt_ch;
  logic [2:0]  state;
`ifdef FILT_BYPASS_EN
  logic bypass;
`endif

  assign rx_empty = (rx_rd == rx_wr) || rx_hold;
  assign r_data   = rx_buf[rx_rd[4:0]];

  uart_filter_ctrl #(.SAMPLE_BYTES(2), .NUM_CH(2)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .filt_in    (filt_in),
    .filt_ch    (filt_ch),
    .filt_start (filt_start),
    .filt_done  (filt_done),
    .filt_out   (filt_out),
`ifdef FILT_BYPASS_EN
    .bypass     (bypass),
`endif
    .state      (state),
    .busy       (busy)
  );

  // Filter model: done three cycles after start, result = input + 1.
  int   mcnt;
  logic mdl_done;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        mcnt <= 0;
    else if (filt_start) mcnt <= 3;
    else if (mcnt != 0)  mcnt <= mcnt - 1;
  end
  assign mdl_done  = (mcnt == 1);
  assign filt_done = mdl_done | extra_done;
  assign filt_out  = filt_in + 16'd1;

  int          cyc = 0;
  int          tx_n = 0;
  int          st_n = 0;
  int          done_cyc = 0;
  logic [7:0]  tx_buf  [0:31];
  int          tx_cyc  [0:31];
  int          pop_cyc [0:31];
  logic [15:0] st_in   [0:15];
  logic [0:0]  st_ch   [0:15];
  int          st_cyc  [0:15];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin
      pop_cyc[rx_rd] <= cyc;
      rx_rd <= rx_rd + 1;
    end
    if (wr_uart) begin
      tx_buf[tx_n] <= w_data;
      tx_cyc[tx_n] <= cyc;
      tx_n <= tx_n + 1;
    end
    if (filt_start) begin
      st_in[st_n]  <= filt_in;
      st_ch[st_n]  <= filt_ch;
      st_cyc[st_n] <= cyc;
      st_n <= st_n + 1;
    end
    if (mdl_done) done_cyc <= cyc;
  end

  // Degenerate instance: one byte per sample, one channel.
  logic       rx_empty1, rd_uart1, wr_uart1, filt_start1, filt_done1, busy1;
  logic [7:0] r_data1, w_data1, filt_in1, filt_out1;
  logic [0:0] filt_ch1;
  logic [2:0] state1;
  int         m1cnt;
  int         rd1_n = 0;
  int         wr1_n = 0;
  int         st1_n = 0;
  logic [7:0] tx1_buf [0:7];
  logic [0:0] st1_ch  [0:7];

  uart_filter_ctrl #(.SAMPLE_BYTES(1), .NUM_CH(1)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_empty   (rx_empty1),
    .r_data     (r_data1),
    .rd_uart    (rd_uart1),
    .tx_full    (1'b0),
    .w_data     (w_data1),
    .wr_uart    (wr_uart1),
    .filt_in    (filt_in1),
    .filt_ch    (filt_ch1),
    .filt_start (filt_start1),
    .filt_done  (filt_done1),
    .filt_out   (filt_out1),
`ifdef FILT_BYPASS_EN
    .bypass     (1'b0),
`endif
    .state      (state1),
    .busy       (busy1)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)         m1cnt <= 0;
    else if (filt_start1) m1cnt <= 3;
    else if (m1cnt != 0)  m1cnt <= m1cnt - 1;
  end
  assign filt_done1 = (m1cnt == 1);
  assign filt_out1  = filt_in1 + 8'd1;

  always @(posedge clk) begin
    if (rd_uart1) rd1_n <= rd1_n + 1;
    if (wr_uart1) begin
      tx1_buf[wr1_n] <= w_data1;
      wr1_n <= wr1_n + 1;
    end
    if (filt_start1) begin
      st1_ch[st1_n] <= filt_ch1;
      st1_n <= st1_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_buf[rx_wr[4:0]] = b;
    rx_wr++;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_n < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(tx_n), 32'(n));
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k = 0;
    while (state !== s && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  logic [7:0] exp2 [0:5];
  int         k;

  initial begin
    reset_n    = 1'b0;
    rx_hold    = 1'b0;
    tx_full    = 1'b0;
    extra_done = 1'b0;
    rx_empty1  = 1'b1;
    r_data1    = 8'h00;
`ifdef FILT_BYPASS_EN
    bypass     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {filt_in, w_data, state, busy, filt_start, wr_uart, rd_uart, filt_ch}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single sample through the filter.
    push(8'h34);
    push(8'h12);
    wait_tx(2, "t1_tx_timeout");
    check("t1_filt_in", 32'(st_in[0]), 32'h1234);
    check("t1_filt_ch", 32'(st_ch[0]), 32'd0);
    check("t1_tx0", 32'(tx_buf[0]), 32'h35);
    check("t1_tx1", 32'(tx_buf[1]), 32'h12);
    check("t1_start_lat", 32'(st_cyc[0] - pop_cyc[1]), 32'd1);
    check("t1_send_lat", 32'(tx_cyc[0] - done_cyc), 32'd1);
    check("t1_idle", {28'h0, state, busy}, 32'h0);

    // filt_done while idle must not move the FSM.
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    @(negedge clk);
    check("stray_done_state", 32'(state), 32'd0);
    check("stray_done_starts", 32'(st_n), 32'd1);

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Three back-to-back samples, channel interleave 0,1,0.
    push(8'h01); push(8'h00);
    push(8'hFF); push(8'h10);
    push(8'h00); push(8'h80);
    exp2[0] = 8'h02; exp2[1] = 8'h00;
    exp2[2] = 8'h00; exp2[3] = 8'h11;
    exp2[4] = 8'h01; exp2[5] = 8'h80;
    wait_tx(8, "t2_tx_timeout");
    for (int i = 0; i < 6; i++) check($sformatf("t2_tx%0d", i), 32'(tx_buf[2+i]), 32'(exp2[i]));
    check("t2_ch0", 32'(st_ch[1]), 32'd0);
    check("t2_ch1", 32'(st_ch[2]), 32'd1);
    check("t2_ch2", 32'(st_ch[3]), 32'd0);
    check("t2_in1", 32'(st_in[2]), 32'h10FF);
    check("t2_pops", 32'(rx_rd), 32'd8);

    // RX gap mid-sample and TX back-pressure in SEND.
    tx_full = 1'b1;
    push(8'h78);
    k = 0;
    while (rx_rd < 9 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_first_pop", 32'(rx_rd), 32'd9);
    rx_hold = 1'b1;
    push(8'h56);
    repeat (10) @(negedge clk);
    check("t3_hold_state", {28'h0, state, busy}, 32'h1);
    check("t3_hold_pops", 32'(rx_rd), 32'd9);
    rx_hold = 1'b0;
    wait_state(3'd3, "t3_reach_send");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_full%0d", i), {23'h0, wr_uart, w_data}, 32'h079);
    end
    tx_full = 1'b0;
    wait_tx(10, "t3_tx_timeout");
    repeat (3) @(negedge clk);
    check("t3_tx0", 32'(tx_buf[8]), 32'h79);
    check("t3_tx1", 32'(tx_buf[9]), 32'h56);
    check("t3_ch", 32'(st_ch[4]), 32'd1);
    check("t3_push_count", 32'(tx_n), 32'd10);
    check("t3_pop_count", 32'(rx_rd), 32'd10);

    // Reset in the middle of SEND with channel 1 active.
    push(8'h00); push(8'h00);
    wait_tx(12, "t4a_tx_timeout");
    push(8'h11); push(8'h22);
    wait_tx(13, "t4b_tx_timeout");
    check("t4_pre_state", {29'h0, state}, 32'h3);
    check("t4_pre_ch", 32'(filt_ch), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_reset_outputs",
          {filt_in, w_data, state, busy, filt_start, wr_uart, rd_uart, filt_ch}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_no_stray_push", 32'(tx_n), 32'd13);
    push(8'hEF); push(8'hBE);
    wait_tx(15, "t4c_tx_timeout");
    check("t4_tx0", 32'(tx_buf[13]), 32'hF0);
    check("t4_tx1", 32'(tx_buf[14]), 32'hBE);
    check("t4_in", 32'(st_in[7]), 32'hBEEF);
    check("t4_ch", 32'(st_ch[7]), 32'd0);

`ifdef FILT_BYPASS_EN
    bypass = 1'b1;
    push(8'hAA); push(8'h55);
    wait_tx(17, "t5_tx_timeout");
    check("t5_tx0", 32'(tx_buf[15]), 32'hAA);
    check("t5_tx1", 32'(tx_buf[16]), 32'h55);
    check("t5_no_start", 32'(st_n), 32'd8);
    check("t5_lat", 32'(tx_cyc[15] - pop_cyc[17]), 32'd1);
    bypass = 1'b0;
`endif

    // Degenerate build: single byte, single channel.
    r_data1   = 8'h7F;
    rx_empty1 = 1'b0;
    @(negedge clk);
    rx_empty1 = 1'b1;
    k = 0;
    while (wr1_n < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_push_count", 32'(wr1_n), 32'd1);
    check("t6_tx0", 32'(tx1_buf[0]), 32'h80);
    check("t6_pop_count", 32'(rd1_n), 32'd1);
    r_data1   = 8'hFF;
    rx_empty1 = 1'b0;
    @(negedge clk);
    rx_empty1 = 1'b1;
    k = 0;
    while (wr1_n < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_tx1", 32'(tx1_buf[1]), 32'h00);
    check("t6_ch0", 32'(st1_ch[0]), 32'd0);
    check("t6_ch1", 32'(st1_ch[1]), 32'd0);
    check("t6_idle", {28'h0, state1, busy1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_filter_ctrl.md
# uart_filter_ctrl

Parametrised stream controller between the UART byte FIFOs and an external filter core (e.g. biquad_filter). Pops little-endian multi-byte samples from the RX FIFO, tags each with a round-robin channel index, runs a start/done handshake with the filter, and pushes the result bytes into the TX FIFO. Successor to the fixed single-byte, single-channel `state` controller; it adds sample width, channel interleaving, FIFO back-pressure stalls and an optional bypass.

## Interface
- SAMPLE_BYTES, 2, bytes per sample, ≥1; SAMPLE_W = 8·SAMPLE_BYTES (derived)
- NUM_CH, 2, interleaved channels, ≥1; CH_W = max(1, clog2(NUM_CH)) (derived)
- clk  in  1  single system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty
- r_data  in  8  RX FIFO head byte, valid while !rx_empty
- rd_uart  out  1  one-cycle pop of RX FIFO
- tx_full  in  1  TX FIFO full
- w_data  out  8  byte to TX FIFO
- wr_uart  out  1  one-cycle push to TX FIFO
- filt_in  out  SAMPLE_W  assembled sample, stable from filt_start until filt_done
- filt_ch  out  CH_W  channel of filt_in
- filt_start  out  1  one-cycle request to the filter
- filt_done  in  1  one-cycle completion; filt_out valid in that cycle
- filt_out  in  SAMPLE_W  filter result
- bypass  in  1  skip filter (only with FILT_BYPASS_EN)
- state  out  3  encoded FSM state, for LEDs
- busy  out  1  high in every state except RECV with byte index 0

## Operation
- States: RECV(0), START(1), WAIT(2), SEND(3).
- RECV: rd_uart = !rx_empty (combinational). Each pop stores r_data at byte index b (b=0 → bits 7:0), b++. Pop at b = SAMPLE_BYTES−1 → START, b cleared.
- START: filt_start=1 one cycle → WAIT.
- WAIT: on filt_done capture filt_out into result register → SEND. No timeout.
- SEND: wr_uart = !tx_full; w_data = result byte b, LSB first. Push at b = SAMPLE_BYTES−1 → RECV, b cleared, channel = (channel+1) mod NUM_CH.
- Stalls: rx_empty mid-sample holds RECV with partial bytes; tx_full holds SEND with w_data stable. No bytes lost or duplicated.
- filt_done outside WAIT is ignored.
- Reset (any state, any time): all outputs 0, state RECV, b=0, channel 0, data registers 0; partial sample discarded.
- Degenerate: SAMPLE_BYTES=1 → single pop/push per sample; NUM_CH=1 → filt_ch constant 0.

## Timing
- Pop and push each occur in the same cycle as the condition; at most one byte per clock.
- Filter path: last pop cycle N; filt_start at N+1; WAIT from N+2; filt_done earliest N+2; first wr_uart at done+1.
- Bypass path: last pop N; first wr_uart at N+1.
- Sustained throughput (no stalls, done at N+2): 2·SAMPLE_BYTES+2 cycles per sample.

## Configuration
- FILT_BYPASS_EN defined: `bypass` port exists, sampled in the cycle of the last RX pop; if 1, result = filt_in, RECV → SEND directly, filt_start not asserted, channel still advances. Changes mid-sample take effect next sample.
- Undefined: no `bypass` port; every sample goes through the filter.

## Structure
- Package uart_filt_pkg: state enum (RECV/START/WAIT/SEND, 3-bit), BYTE_W = 8 constant.
- One sub-module: byte_shifter (SAMPLE_BYTES × 8 register with indexed byte write and indexed byte read), instantiated twice (assembly and result).
- FSM, byte counter and channel counter stay in uart_filter_ctrl.

## Test plan
- Defaults, filter model with done 3 cycles after start returning in+1: RX 0x34,0x12 → filt_in=0x1234, filt_ch=0 → TX 0x35,0x12.
- Three samples, NUM_CH=2: filt_ch sequence 0,1,0; bytes in order, no loss.
- rx_empty held 10 cycles between bytes 1 and 2, tx_full held 5 cycles in SEND → identical output, no extra rd_uart/wr_uart pulses.
- reset_n low for 1 cycle mid-SEND → outputs 0 immediately, channel 0; next sample 0xBEEF → TX 0xEF(+1 model),0xBE on channel 0.
- FILT_BYPASS_EN, bypass=1: RX 0xAA,0x55 → no filt_start, TX 0xAA,0x55, first wr_uart one cycle after last rd_uart.
- SAMPLE_BYTES=1, NUM_CH=1: RX 0x7F → TX model(0x7F)=0x80, filt_ch always 0.
